pixel_fill_engine: RTL

//  Hardware drawing engine between the Nios II PIOs and the dual-port pixel buffer write port.

---
 rtl/pixel_fill_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_fill_engine.sv
// Drawing engine: single pixel, clipped rectangle or full clear into the pixel buffer write port; optional PIXEL_FILL_PIXCNT_EN adds pix_count.
// Latency: accept edge -> first write 2 clks later, one write per clk, done 1 clk after the last write.
// Backpressure: none; start edges arriving while busy are dropped, the write port is never stalled.
module pixel_fill_engine #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [1:0]        cmd_mode,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [X_W-1:0]    cmd_w,
    input  logic [Y_W-1:0]    cmd_h,
    input  logic [PIX_W-1:0]  cmd_colour,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pb_wraddress,
    output logic [PIX_W-1:0]  pb_data,
    output logic              pb_wren
`ifdef PIXEL_FILL_PIXCNT_EN
    ,
    output logic [ADDR_W:0]   pix_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_RUN, S_DONE} state_t;

    localparam logic [1:0]        MODE_PIXEL = 2'b00;
    localparam logic [1:0]        MODE_CLEAR = 2'b10;
    localparam logic [1:0]        MODE_RSVD  = 2'b11;
    localparam logic [X_W:0]      X_LIM      = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      Y_LIM      = (Y_W+1)'(V_RES);
    localparam logic [X_W:0]      X_ONE      = (X_W+1)'(1);
    localparam logic [Y_W:0]      Y_ONE      = (Y_W+1)'(1);
    localparam logic [X_W-1:0]    CX_INC     = X_W'(1);
    localparam logic [Y_W-1:0]    CY_INC     = Y_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(1);

    state_t             state;
    logic               start_q;
    logic               start_edge;
    logic [1:0]         mode_l;
    logic [X_W-1:0]     x_l, w_l;
    logic [Y_W-1:0]     y_l, h_l;
    logic [PIX_W-1:0]   colour_l;
    logic [X_W-1:0]     x0, cx;
    logic [Y_W-1:0]     cy;
    logic [X_W:0]       x_end;
    logic [Y_W:0]       y_end;
    logic [ADDR_W-1:0]  row_base;

    logic [X_W-1:0]     clip_x, clip_w;
    logic [Y_W-1:0]     clip_y, clip_h;
    logic [X_W:0]       x_sum, x_end_c;
    logic [Y_W:0]       y_sum, y_end_c;
    logic               clip_empty;
    logic [ADDR_W-1:0]  row_base_c;
    logic               last_col, last_row;

    assign start_edge = cmd_start & ~start_q;
    assign last_col   = (({1'b0, cx} + X_ONE) == x_end);
    assign last_row   = (({1'b0, cy} + Y_ONE) == y_end);

    // Clip window from the latched command; only evaluated while in CLIP.
    always_comb begin
        clip_x = x_l;
        clip_y = y_l;
        clip_w = w_l;
        clip_h = h_l;
        if (mode_l == MODE_PIXEL) begin
            clip_w = CX_INC;
            clip_h = CY_INC;
        end
        if (mode_l == MODE_CLEAR) begin
            clip_x = '0;
            clip_y = '0;
        end
        x_sum      = {1'b0, clip_x} + {1'b0, clip_w};
        y_sum      = {1'b0, clip_y} + {1'b0, clip_h};
        x_end_c    = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_end_c    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        clip_empty = ({1'b0, clip_x} >= X_LIM) || ({1'b0, clip_y} >= Y_LIM) ||
                     (clip_w == '0) || (clip_h == '0);
        if (mode_l == MODE_CLEAR) begin
            x_end_c    = X_LIM;
            y_end_c    = Y_LIM;
            clip_empty = 1'b0;
        end
        row_base_c = ADDR_W'(clip_y) * ROW_STEP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            mode_l       <= '0;
            x_l          <= '0;
            y_l          <= '0;
            w_l          <= '0;
            h_l          <= '0;
            colour_l     <= '0;
            x0           <= '0;
            cx           <= '0;
            cy           <= '0;
            x_end        <= '0;
            y_end        <= '0;
            row_base     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pb_wraddress <= '0;
            pb_data      <= '0;
            pb_wren      <= 1'b0;
        end else begin
            start_q <= cmd_start;
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start_edge) begin
                        mode_l   <= cmd_mode;
                        x_l      <= cmd_x;
                        y_l      <= cmd_y;
                        w_l      <= cmd_w;
                        h_l      <= cmd_h;
                        colour_l <= cmd_colour;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (mode_l == MODE_RSVD || clip_empty) begin
                        err   <= (mode_l == MODE_RSVD);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        // First pixel is issued here so the write stream starts one clk after CLIP.
                        x0           <= clip_x;
                        cx           <= clip_x;
                        cy           <= clip_y;
                        x_end        <= x_end_c;
                        y_end        <= y_end_c;
                        row_base     <= row_base_c;
                        pb_wraddress <= row_base_c + ADDR_W'(clip_x);
                        pb_data      <= colour_l;
                        pb_wren      <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_col && last_row) begin
                        pb_wren <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (last_col) begin
                        cx           <= x0;
                        cy           <= cy + CY_INC;
                        row_base     <= row_base + ROW_STEP;
                        pb_wraddress <= row_base + ROW_STEP + ADDR_W'(x0);
                    end else begin
                        cx           <= cx + CX_INC;
                        pb_wraddress <= pb_wraddress + ADDR_INC;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PIXEL_FILL_PIXCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_count <= '0;
        end else if (state == S_IDLE && start_edge) begin
            pix_count <= '0;
        end else if (pb_wren) begin
            pix_count <= pix_count + (ADDR_W+1)'(1);
        end
    end
`endif

endmodule
